// File: rtl/dshot_frame_sequencer_if.sv
// Command handshake between the throttle/command source and the DShot sequencer.
interface dshot_frame_sequencer_if;
   logic        cmd_valid;
   logic        cmd_ready;
   logic [10:0] cmd_value;
   logic        cmd_telem;

   modport master (output cmd_valid, cmd_value, cmd_telem, input cmd_ready);
   modport slave  (input cmd_valid, cmd_value, cmd_telem, output cmd_ready);
endinterface

// File: rtl/dshot_frame_sequencer.sv
// Turns 11-bit DShot words into timed 16-bit pulse frames plus inter-frame gap,
// optionally re-sending the last frame so the ESC never loses signal.
module dshot_frame_sequencer #(
   parameter int BIT_CLKS = 27,
   parameter int T1H_CLKS = 20,
   parameter int T0H_CLKS = 10,
   parameter int GAP_CLKS = 64
) (
   input  logic                     clk_in,
   input  logic                     rst,
   input  logic                     enable,
   input  logic                     repeat_en,
   dshot_frame_sequencer_if.slave   cmd,
   output logic                     dshot_out,
   output logic                     busy,
   output logic                     frame_done
);
   localparam int PW = $clog2(BIT_CLKS);
   localparam int GW = $clog2(GAP_CLKS + 1);

   typedef enum logic [1:0] {IDLE, BIT, GAP} state_t;

   state_t        state, state_d;
   logic [PW-1:0] phase, phase_d;
   logic [3:0]    idx, idx_d;
   logic [GW-1:0] gcnt, gcnt_d;
   logic [15:0]   frame, frame_d;
   logic          have_frame, have_frame_d;
   logic          live;
   logic          accept;
   logic          dshot_d;
   logic [11:0]   v;

   // live holds cmd_ready low until the first edge after reset release
   assign v             = {cmd.cmd_value, cmd.cmd_telem};
   assign cmd.cmd_ready = live && (state == IDLE) && enable;
   assign accept        = cmd.cmd_valid && cmd.cmd_ready;
   assign busy          = (state != IDLE);
   assign frame_done    = (state == GAP) && (gcnt == GW'(GAP_CLKS - 1));

   always_ff @(posedge clk_in or posedge rst) begin
      if (rst) begin
         state      <= IDLE;
         phase      <= '0;
         idx        <= '0;
         gcnt       <= '0;
         frame      <= '0;
         have_frame <= 1'b0;
         live       <= 1'b0;
         dshot_out  <= 1'b0;
      end else begin
         state      <= state_d;
         phase      <= phase_d;
         idx        <= idx_d;
         gcnt       <= gcnt_d;
         frame      <= frame_d;
         have_frame <= have_frame_d;
         live       <= 1'b1;
         dshot_out  <= dshot_d;
      end
   end

   always_comb begin
      state_d      = state;
      phase_d      = phase;
      idx_d        = idx;
      gcnt_d       = gcnt;
      frame_d      = frame;
      have_frame_d = have_frame;
      case (state)
         IDLE: begin
            if (accept) begin
               frame_d      = {v, v[3:0] ^ v[7:4] ^ v[11:8]};
               have_frame_d = 1'b1;
               state_d      = BIT;
               idx_d        = 4'd15;
               phase_d      = '0;
            end else if (live && enable && repeat_en && have_frame) begin
               state_d = BIT;
               idx_d   = 4'd15;
               phase_d = '0;
            end
         end
         BIT: begin
            if (phase == PW'(BIT_CLKS - 1)) begin
               phase_d = '0;
               if (idx == 4'd0) begin
                  state_d = GAP;
                  gcnt_d  = '0;
               end else begin
                  idx_d = idx - 4'd1;
               end
            end else begin
               phase_d = phase + 1'b1;
            end
         end
         GAP: begin
            if (frame_done) state_d = IDLE;
            else            gcnt_d  = gcnt + 1'b1;
         end
         default: state_d = IDLE;
      endcase
      // Output is decided from next-state values so the pin is a clean flop
      // that goes high on the very first BIT cycle.
      dshot_d = (state_d == BIT) &&
                (phase_d < (frame_d[idx_d] ? PW'(T1H_CLKS) : PW'(T0H_CLKS)));
   end
endmodule

// File: tb/tb_dshot_frame_sequencer.sv
// Randomized bench: a frame-offset model predicts every output each cycle, and
// a pulse-width decoder recovers sent words for literal/timing checks.
module tb_dshot_frame_sequencer;
   localparam int BIT_CLKS = 27;
   localparam int T1H      = 20;
   localparam int T0H      = 10;
   localparam int GAP      = 64;
   localparam int FLEN     = 16 * BIT_CLKS + GAP;   // busy cycles per frame

   logic clk = 0, rst = 0, enable = 0, repeat_en = 0;
   logic dshot_out, busy, frame_done;
   int   checks = 0, failures = 0;

   dshot_frame_sequencer_if cif ();

   dshot_frame_sequencer dut (
      .clk_in(clk), .rst(rst), .enable(enable), .repeat_en(repeat_en),
      .cmd(cif), .dshot_out(dshot_out), .busy(busy), .frame_done(frame_done)
   );

   always #5 clk = ~clk;

   function automatic logic [15:0] build(input int val, input int tel);
      int vv, c;
      vv = (val << 1) | tel;
      c  = (vv ^ (vv >> 4) ^ (vv >> 8)) & 15;
      return 16'((vv << 4) | c);
   endfunction

   // model: idle/active flag plus offset within the current frame
   logic        m_live = 0, m_have = 0, m_active = 0;
   logic [15:0] m_frame = '0;
   int          m_off = 0, acc_cnt = 0, cyc = 0;

   always @(negedge clk) begin
      logic e_d, e_b, e_fd, e_r;
      cyc++;
      if (rst) begin
         e_d = 0; e_b = 0; e_fd = 0; e_r = 0;
      end else begin
         e_b  = m_active;
         e_fd = m_active && (m_off == FLEN - 1);
         e_r  = m_live && !m_active && enable;
         e_d  = 0;
         if (m_active && m_off < 16 * BIT_CLKS)
            e_d = (m_off % BIT_CLKS) < (m_frame[15 - m_off / BIT_CLKS] ? T1H : T0H);
      end
      checks += 4;
      if (dshot_out !== e_d)     begin failures++; $display("FAIL dshot_out cyc=%0d got=%b exp=%b", cyc, dshot_out, e_d); end
      if (busy !== e_b)          begin failures++; $display("FAIL busy cyc=%0d got=%b exp=%b", cyc, busy, e_b); end
      if (frame_done !== e_fd)   begin failures++; $display("FAIL frame_done cyc=%0d got=%b exp=%b", cyc, frame_done, e_fd); end
      if (cif.cmd_ready !== e_r) begin failures++; $display("FAIL cmd_ready cyc=%0d got=%b exp=%b", cyc, cif.cmd_ready, e_r); end
      if (rst) begin
         m_live = 0; m_have = 0; m_active = 0; m_frame = '0; m_off = 0;
      end else begin
         if (m_active) begin
            if (m_off == FLEN - 1) m_active = 0;
            else m_off++;
         end else if (e_r && cif.cmd_valid) begin
            m_frame = build(int'(cif.cmd_value), int'(cif.cmd_telem));
            m_have = 1; m_active = 1; m_off = 0; acc_cnt++;
         end else if (m_live && enable && repeat_en && m_have) begin
            m_active = 1; m_off = 0;
         end
         m_live = 1;
      end
   end

   // decoder: high-time per bit, frame word and start cycle of each frame
   logic [15:0] dec_q[$];
   int          start_q[$];
   int          hl = 0, nbits = 0, st = 0;
   logic [15:0] sh = '0;
   logic        prev = 0;
   always @(negedge clk) begin
      if (rst) begin
         hl = 0; nbits = 0; prev = 0;
      end else begin
         if (dshot_out && !prev && nbits == 0) st = cyc;
         if (dshot_out) hl++;
         if (!dshot_out && prev) begin
            sh = {sh[14:0], (hl >= 15)};
            hl = 0; nbits++;
            if (nbits == 16) begin dec_q.push_back(sh); start_q.push_back(st); nbits = 0; end
         end
         prev = dshot_out;
      end
   end

   task automatic chk(input string name, input int got, input int exp);
      checks++;
      if (got != exp) begin
         failures++;
         $display("FAIL %s got=%0h exp=%0h", name, got, exp);
      end
   endtask

   task automatic tick(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic send(input int val, input int tel);
      int base = acc_cnt, k = 0;
      cif.cmd_valid = 1; cif.cmd_value = 11'(val); cif.cmd_telem = tel[0];
      while (acc_cnt == base && k < 1500) begin tick(1); k++; end
      cif.cmd_valid = 0;
      if (acc_cnt == base) chk("send_timeout", 0, 1);
   endtask

   task automatic wait_frames(input int n);
      int base = dec_q.size(), k = 0;
      while (dec_q.size() < base + n && k < 600 * n + 600) begin tick(1); k++; end
      if (dec_q.size() < base + n) chk("frame_timeout", dec_q.size() - base, n);
   endtask

   task automatic wait_off(input int off);
      int k = 0;
      while (!(m_active && m_off == off) && k < 1500) begin tick(1); k++; end
      if (!(m_active && m_off == off)) chk("wait_off_timeout", m_off, off);
   endtask

   initial begin
      int n, v, t;
      cif.cmd_valid = 0; cif.cmd_value = '0; cif.cmd_telem = 0;
      #1 rst = 1; enable = 1;
      #2;
      chk("rst_dshot", dshot_out, 0);
      chk("rst_busy", busy, 0);
      chk("rst_ready", cif.cmd_ready, 0);
      tick(2);
      rst = 0;

      // single frame
      send(1046, 0);
      wait_frames(1);
      chk("frame_1046", dec_q[$], 16'h82C6);
      n = dec_q.size();
      tick(600);
      chk("no_extra_frames", dec_q.size(), n);

      // checksum corners
      send(0, 0);    wait_frames(1); chk("frame_zero", dec_q[$], 16'h0000);
      send(2047, 1); wait_frames(1); chk("frame_ffff", dec_q[$], 16'hFFFF);

      // repeat stream, then a new command mid-frame
      repeat_en = 1;
      v = $urandom_range(0, 2047);
      send(v, 0);
      wait_frames(3);
      chk("repeat_period", start_q[$] - start_q[$-1], 497);
      chk("repeat_same", dec_q[$], dec_q[$-1]);
      chk("repeat_value", dec_q[$], build(v, 0));
      wait_off(100);
      n = dec_q.size();
      send(48, 0);
      wait_frames(2);
      chk("inflight_kept", dec_q[n], build(v, 0));
      chk("cmd48", dec_q[n + 1], 16'h0606);

      // enable dropped mid-frame
      wait_off(50);
      enable = 0;
      n = dec_q.size();
      tick(1200);
      chk("enable_off_frames", dec_q.size(), n + 1);
      chk("enable_off_line", dshot_out, 0);
      cif.cmd_valid = 1; cif.cmd_value = 11'd777; cif.cmd_telem = 1;
      tick(5);
      enable = 1;
      tick(1);
      cif.cmd_valid = 0;
      chk("enable_start_dshot", dshot_out, 1);
      chk("enable_start_busy", busy, 1);
      wait_frames(1);
      chk("frame_777", dec_q[$], build(777, 1));

      // async reset during bit 7 high phase
      wait_off(8 * BIT_CLKS + 3);
      chk("bit7_high", dshot_out, 1);
      #2 rst = 1;
      #1 chk("async_rst_dshot", dshot_out, 0);
      tick(2);
      rst = 0;
      n = dec_q.size();
      tick(700);
      chk("no_frame_after_rst", dec_q.size(), n);
      chk("rst_line_low", dshot_out, 0);

      // randomized commands and mode toggles
      for (int i = 0; i < 8; i++) begin
         v = $urandom_range(0, 2047);
         t = $urandom_range(0, 1);
         repeat_en = $urandom_range(0, 1);
         send(v, t);
         wait_frames(1);
         chk("rand_frame", dec_q[$], build(v, t));
         tick($urandom_range(0, 700));
      end
      repeat_en = 0;
      tick(600);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule

// File: doc/dshot_frame_sequencer.md
Name: dshot_frame_sequencer

Overview:
- Converts 11-bit DShot throttle/command words into timed DShot pulse frames on one output pin, clocked from the 16 MHz board clock.
- Sequences each frame: latch, 4-bit checksum, 16-bit MSB-first serialisation with per-bit high/low timing, then inter-frame gap.
- Optionally re-sends the last frame continuously so the ESC never sees signal loss.
- Sits between the command source (upstream decoder or test pattern) and the ESC output pin.

Parameters:
- BIT_CLKS, 27, clocks per bit period (DShot600 at 16 MHz; 53 selects DShot300).
- T1H_CLKS, 20, high time of a '1' bit in clocks.
- T0H_CLKS, 10, high time of a '0' bit in clocks.
- GAP_CLKS, 64, low clocks after the last bit before the frame is done.

Ports:
- clk_in  input  1  system clock, 16 MHz
- rst  input  1  asynchronous active-high reset
- enable  input  1  permits new frames to start; a frame in flight always completes
- repeat_en  input  1  re-send the latched frame when no new command is pending
- cmd_valid  input  1  command word offered
- cmd_ready  output  1  sequencer accepts a command this cycle
- cmd_value  input  11  throttle/command value (0..2047)
- cmd_telem  input  1  telemetry request bit
- dshot_out  output  1  DShot line (idle low)
- busy  output  1  high from frame start through the end of the gap
- frame_done  output  1  one-cycle pulse on the last gap cycle

Behaviour:
- Reset (async, any time including mid-frame): dshot_out=0, busy=0, frame_done=0, cmd_ready=0 until the first clock edge after reset release, state=IDLE, latched frame cleared, have_frame=0.
- States: IDLE, BIT, GAP.
- cmd_ready = (state==IDLE) && enable, combinational from registered state.
- IDLE start priority:
  - cmd_valid&&cmd_ready: latch the new command. cmd_valid has priority over repeat.
  - Else if enable && repeat_en && have_frame: reuse the latched frame.
  - Else stay in IDLE.
- Frame build at latch: v = {cmd_value, cmd_telem} (12 bits); crc = (v ^ (v>>4) ^ (v>>8)) & 4'hF; frame = {v, crc}, 16 bits. Set have_frame=1.
- Start: on the cycle after acceptance, state=BIT, bit index 15, phase counter 0. dshot_out=1 that same cycle.
- BIT state:
  - Phase counter counts 0..BIT_CLKS-1.
  - dshot_out=1 while phase < (bit ? T1H_CLKS : T0H_CLKS); otherwise 0.
  - At phase BIT_CLKS-1: if index 0, go to GAP; else decrement the index and reset phase to 0.
- GAP state: dshot_out=0 for GAP_CLKS cycles. frame_done=1 on the last of those cycles, then go to IDLE.
- busy=1 in BIT and GAP.
- Timing:
  - Frame-to-frame period in repeat mode is exactly 16*BIT_CLKS + GAP_CLKS + 1 clocks (one IDLE cycle). Default: 497 clocks.
  - A command accepted during a repeat stream takes effect on the next frame; the frame in flight is never altered.
- enable dropped mid-frame: the current frame and gap complete, then the block stays in IDLE.
- dshot_out is registered, glitch-free, and low in IDLE.
- Parameter legality: T0H_CLKS < T1H_CLKS < BIT_CLKS, GAP_CLKS ≥ 1. No behaviour is defined otherwise.

Test Plan:
- Single frame: cmd_value=1046, telem=0, enable=1, repeat_en=0 → frame 16'h82C6. Sixteen bit periods of 27 clocks each, high for 20 on '1' bits and 10 on '0' bits. Then 64 low clocks, frame_done pulses once, busy falls, no further frames.
- Checksum corners: value=0/telem=0 → 16'h0000, all bits high 10 clocks. Value=2047/telem=1 → v=12'hFFF, crc=4'hF, 16'hFFFF, all bits high 20 clocks.
- Repeat: after one accepted command with repeat_en=1 and cmd_valid=0 → identical frames with rising edges exactly 497 clocks apart. Assert cmd_valid=1 with value=48 mid-frame → the current frame completes unchanged and the next frame carries value 48.
- Handshake: cmd_valid held high during busy → cmd_ready=0 and no acceptance until IDLE. Exactly one acceptance per frame, and cmd_valid beats repeat.
- Enable: drop enable mid-frame → frame and gap finish, then dshot_out stays 0 and cmd_ready=0. Raise enable → a pending command starts the next cycle.
- Reset mid-frame: assert rst during bit 7 high phase → dshot_out=0 immediately (async). After release with repeat_en=1 → no frame sent (have_frame cleared) until a new command is accepted.
